// File: rtl/dct2d_seq_ctrl_if.sv
// Handshake and control bundle between the 2D DCT sequencer and its
// neighbours: block source, block sink and the shared DCT1D datapath.
interface dct2d_seq_ctrl_if #(
  parameter int CNT_W = 4,
  parameter int BLK_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             ld_in;
  logic             pass_sel;
  logic [CNT_W-1:0] clk_cnt;
  logic             ld_mid;
  logic             ld_out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic [BLK_W-1:0] blk_cnt;

  // Sequencer side
  modport master (
    input  in_valid, out_ready,
    output in_ready, ld_in, pass_sel, clk_cnt, ld_mid, ld_out,
           out_valid, busy, blk_cnt
  );

  // Source / sink / datapath side
  modport slave (
    output in_valid, out_ready,
    input  in_ready, ld_in, pass_sel, clk_cnt, ld_mid, ld_out,
           out_valid, busy, blk_cnt
  );
endinterface

// File: rtl/dct2d_seq_ctrl.sv
// Sequencer for one shared DCT1D datapath used twice per 8x8 block:
// row pass, transposed mid capture, column pass, output capture.
// in_ready/ld_in are combinational so a new block can be accepted in the
// same cycle the finished one is handed to the sink; everything else is
// registered.
module dct2d_seq_ctrl #(
  parameter int STAGES = 5,
  parameter int CNT_W  = 4,
  parameter int BLK_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  dct2d_seq_ctrl_if.master bus
);

  // Reject stage counts the counter cannot represent or the datapath lacks.
  generate
    if (STAGES < 1 || STAGES > 15 || STAGES > (2**CNT_W) - 1) begin : g_bad_stages
      $error("dct2d_seq_ctrl: STAGES=%0d illegal for CNT_W=%0d", STAGES, CNT_W);
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ROW  = 3'd1,
    MID  = 3'd2,
    COL  = 3'd3,
    CAP  = 3'd4,
    OUT  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(STAGES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] clk_cnt;
  logic             ld_mid;
  logic             ld_out;
  logic             pass_sel;
  logic             out_valid;
  logic             busy;
  logic [BLK_W-1:0] blk_cnt;

  logic in_ready;
  logic accept;
  logic out_hs;

  // A block can enter when idle, or when the finished block leaves this cycle.
  assign in_ready = ((state == IDLE) | ((state == OUT) & bus.out_ready)) & rst_n;
  assign accept   = bus.in_valid & in_ready;
  assign out_hs   = out_valid & bus.out_ready;

  // Sequencer FSM with registered strobes, stage index and block counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      ld_mid    <= 1'b0;
      ld_out    <= 1'b0;
      pass_sel  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      blk_cnt   <= '0;
    end else begin
      ld_mid <= 1'b0;
      ld_out <= 1'b0;
      if (out_hs) begin
        blk_cnt <= blk_cnt + BLK_W'(1);
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= ROW;
            clk_cnt <= CNT_ONE;
            busy    <= 1'b1;
          end
        end
        ROW: begin
          if (clk_cnt == LAST_STAGE) begin
            // Row results are stable next cycle: capture them transposed.
            state    <= MID;
            clk_cnt  <= '0;
            ld_mid   <= 1'b1;
            pass_sel <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end
        MID: begin
          state   <= COL;
          clk_cnt <= CNT_ONE;
        end
        COL: begin
          if (clk_cnt == LAST_STAGE) begin
            state   <= CAP;
            clk_cnt <= '0;
            ld_out  <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end
        CAP: begin
          state     <= OUT;
          pass_sel  <= 1'b0;
          out_valid <= 1'b1;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            if (accept) begin
              state   <= ROW;
              clk_cnt <= CNT_ONE;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          clk_cnt   <= '0;
          pass_sel  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.ld_in     = accept;
  assign bus.pass_sel  = pass_sel;
  assign bus.clk_cnt   = clk_cnt;
  assign bus.ld_mid    = ld_mid;
  assign bus.ld_out    = ld_out;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.blk_cnt   = blk_cnt;

endmodule
